// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_light_ctrl
//  Purpose  : Main/side road and pedestrian phase sequencer with a 1 s tick,
//             demand-driven main-green extension and a seconds-left display.
//  Revision : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int T_MAIN_MIN = 10,
    parameter int T_MAIN_MAX = 30,
    parameter int T_YELLOW   = 3,
    parameter int T_ALLRED   = 1,
    parameter int T_SIDE     = 10,
    parameter int T_WALK     = 8
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       car_side,
    input  logic       ped_btn,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk,
    output logic [7:0] sec_remaining,
    output logic [2:0] state
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TW-1:0] c_tick_last = TW'(TICK_DIV - 1);
    localparam logic [7:0]    c_main_min  = 8'(T_MAIN_MIN);
    localparam logic [7:0]    c_main_max  = 8'(T_MAIN_MAX);
    localparam logic [7:0]    c_yellow_t  = 8'(T_YELLOW);
    localparam logic [7:0]    c_allred_t  = 8'(T_ALLRED);
    localparam logic [7:0]    c_side_t    = 8'(T_SIDE);
    localparam logic [7:0]    c_walk_t    = 8'(T_WALK);

    localparam logic [2:0] c_red    = 3'b100;
    localparam logic [2:0] c_yellow = 3'b010;
    localparam logic [2:0] c_green  = 3'b001;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        PED_WALK    = 3'd3,
        SIDE_GREEN  = 3'd4,
        SIDE_YELLOW = 3'd5,
        ALL_RED_B   = 3'd6
    } state_t;

    // Raw 3-bit register so the unused code 7 is representable and recoverable.
    logic [2:0]    state_q;
    state_t        state_d;
    logic [7:0]    sec_q, sec_d;
    logic [7:0]    el_q, el_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          car_meta_q, car_s_q;
    logic          ped_meta_q, ped_s_q, ped_prev_q;
    logic          ped_pending_q, ped_pending_d;
    logic [2:0]    main_q, main_d, side_q, side_d;
    logic          walk_q, walk_d;

    logic          w_tick, w_demand, w_done, w_chg, w_ped_rise, w_enter_walk;
    logic [7:0]    w_el_next;

    function automatic logic [7:0] phase_len(input state_t s);
        case (s)
            MAIN_GREEN:  phase_len = c_main_max;
            MAIN_YELLOW: phase_len = c_yellow_t;
            ALL_RED_A:   phase_len = c_allred_t;
            PED_WALK:    phase_len = c_walk_t;
            SIDE_GREEN:  phase_len = c_side_t;
            SIDE_YELLOW: phase_len = c_yellow_t;
            default:     phase_len = c_allred_t;
        endcase
    endfunction

    assign w_tick     = (tick_cnt_q == c_tick_last);
    assign w_demand   = car_s_q | ped_pending_q;
    assign w_done     = w_tick && (sec_q == 8'd1);
    assign w_el_next  = el_q + 8'd1;
    assign w_ped_rise = ped_s_q & ~ped_prev_q;

    always_comb begin
        state_d = state_t'(state_q);
        sec_d   = sec_q;
        el_d    = el_q;
        case (state_q)
            MAIN_GREEN: begin
                if (w_tick) begin
                    el_d  = w_el_next;
                    sec_d = c_main_max - w_el_next;
                    if (((w_el_next >= c_main_min) && w_demand) || (w_el_next == c_main_max))
                        state_d = MAIN_YELLOW;
                end
            end
            MAIN_YELLOW, ALL_RED_A, PED_WALK, SIDE_GREEN, SIDE_YELLOW, ALL_RED_B: begin
                if (w_done) begin
                    case (state_q)
                        MAIN_YELLOW: state_d = ALL_RED_A;
                        ALL_RED_A:   state_d = ped_pending_q ? PED_WALK : SIDE_GREEN;
                        PED_WALK:    state_d = car_s_q ? SIDE_GREEN : ALL_RED_B;
                        SIDE_GREEN:  state_d = SIDE_YELLOW;
                        SIDE_YELLOW: state_d = ALL_RED_B;
                        default:     state_d = MAIN_GREEN;
                    endcase
                end else if (w_tick) begin
                    sec_d = sec_q - 8'd1;
                end
            end
            default: state_d = ALL_RED_B;
        endcase

        w_chg = (3'(state_d) != state_q);
        if (w_chg) begin
            sec_d = phase_len(state_d);
            el_d  = 8'd0;
        end
    end

    assign tick_cnt_d = (w_tick || w_chg) ? '0 : tick_cnt_q + TW'(1);

    // A fresh button press outranks the clear caused by entering the walk phase.
    assign w_enter_walk  = (state_d == PED_WALK) && (state_q != 3'(PED_WALK));
    assign ped_pending_d = w_ped_rise | (ped_pending_q & ~w_enter_walk);

    always_comb begin
        main_d = c_red;
        side_d = c_red;
        walk_d = 1'b0;
        case (state_d)
            MAIN_GREEN:  main_d = c_green;
            MAIN_YELLOW: main_d = c_yellow;
            SIDE_GREEN:  side_d = c_green;
            SIDE_YELLOW: side_d = c_yellow;
            PED_WALK:    walk_d = 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            state_q       <= 3'(ALL_RED_B);
            sec_q         <= c_allred_t;
            el_q          <= 8'd0;
            tick_cnt_q    <= '0;
            car_meta_q    <= 1'b0;
            car_s_q       <= 1'b0;
            ped_meta_q    <= 1'b0;
            ped_s_q       <= 1'b0;
            ped_prev_q    <= 1'b0;
            ped_pending_q <= 1'b0;
            main_q        <= c_red;
            side_q        <= c_red;
            walk_q        <= 1'b0;
        end else begin
            state_q       <= 3'(state_d);
            sec_q         <= sec_d;
            el_q          <= el_d;
            tick_cnt_q    <= tick_cnt_d;
            car_meta_q    <= car_side;
            car_s_q       <= car_meta_q;
            ped_meta_q    <= ped_btn;
            ped_s_q       <= ped_meta_q;
            ped_prev_q    <= ped_s_q;
            ped_pending_q <= ped_pending_d;
            main_q        <= main_d;
            side_q        <= side_d;
            walk_q        <= walk_d;
        end
    end

    assign main_lights   = main_q;
    assign side_lights   = side_q;
    assign walk          = walk_q;
    assign sec_remaining = sec_q;
    assign state         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_light_ctrl
//  Purpose  : Directed bench for traffic_light_ctrl with TICK_DIV=4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       car_side;
    logic       ped_btn;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk;
    logic [7:0] sec_remaining;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;

    traffic_light_ctrl #(
        .TICK_DIV   (4),
        .T_MAIN_MIN (10),
        .T_MAIN_MAX (30),
        .T_YELLOW   (3),
        .T_ALLRED   (1),
        .T_SIDE     (10),
        .T_WALK     (8)
    ) dut (
        .clk_100MHz    (clk),
        .reset_n       (reset_n),
        .car_side      (car_side),
        .ped_btn       (ped_btn),
        .main_lights   (main_lights),
        .side_lights   (side_lights),
        .walk          (walk),
        .sec_remaining (sec_remaining),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Main and side lamps may never both show something other than red.
    always @(negedge clk) begin
        if (reset_n === 1'b1)
            check("lights_exclusive", 32'((main_lights != 3'b100) && (side_lights != 3'b100)), 32'd0);
    end

    initial begin
        reset_n  = 1'b0;
        car_side = 1'b0;
        ped_btn  = 1'b0;
        step(2);
        check("rst_state", 32'(state), 32'd6);
        check("rst_main", 32'(main_lights), 32'b100);
        check("rst_side", 32'(side_lights), 32'b100);
        check("rst_walk", 32'(walk), 32'd0);
        check("rst_sec", 32'(sec_remaining), 32'd1);
        check("rst_pend", 32'(dut.ped_pending_q), 32'd0);

        // Reset release: MAIN_GREEN on cycle 4
        reset_n = 1'b1;
        step(3);
        check("rel_c3_state", 32'(state), 32'd6);
        step(1);
        check("rel_c4_state", 32'(state), 32'd0);
        check("rel_c4_main", 32'(main_lights), 32'b001);
        check("rel_c4_sec", 32'(sec_remaining), 32'd30);

        // No demand: full 30 s main green then a side cycle
        step(119);
        check("nd_mg_last_state", 32'(state), 32'd0);
        check("nd_mg_last_sec", 32'(sec_remaining), 32'd1);
        step(1);
        check("nd_my_state", 32'(state), 32'd1);
        check("nd_my_main", 32'(main_lights), 32'b010);
        check("nd_my_sec", 32'(sec_remaining), 32'd3);
        step(12);
        check("nd_ara_state", 32'(state), 32'd2);
        step(4);
        check("nd_sg_state", 32'(state), 32'd4);
        check("nd_sg_side", 32'(side_lights), 32'b001);
        check("nd_sg_main", 32'(main_lights), 32'b100);
        check("nd_sg_sec", 32'(sec_remaining), 32'd10);
        step(40);
        check("nd_sy_state", 32'(state), 32'd5);
        check("nd_sy_side", 32'(side_lights), 32'b010);
        step(12);
        check("nd_arb_state", 32'(state), 32'd6);
        step(4);
        check("nd_mg2_state", 32'(state), 32'd0);

        // car_side held: main green cut to 10 s, no walk phase
        car_side = 1'b1;
        step(39);
        check("car_mg_last_state", 32'(state), 32'd0);
        check("car_mg_last_sec", 32'(sec_remaining), 32'd21);
        step(1);
        check("car_my_state", 32'(state), 32'd1);
        step(12);
        check("car_ara_state", 32'(state), 32'd2);
        step(4);
        check("car_sg_state", 32'(state), 32'd4);
        car_side = 1'b0;
        step(56);
        check("car_mg_state", 32'(state), 32'd0);

        // Pedestrian press 10 cycles into main green, no car
        step(10);
        ped_btn = 1'b1;
        step(1);
        ped_btn = 1'b0;
        step(28);
        check("ped_mg_last_state", 32'(state), 32'd0);
        check("ped_pending_set", 32'(dut.ped_pending_q), 32'd1);
        step(1);
        check("ped_my_state", 32'(state), 32'd1);
        step(12);
        check("ped_ara_state", 32'(state), 32'd2);
        step(4);
        check("ped_walk_state", 32'(state), 32'd3);
        check("ped_walk_lamp", 32'(walk), 32'd1);
        check("ped_walk_pend", 32'(dut.ped_pending_q), 32'd0);
        check("ped_walk_sec", 32'(sec_remaining), 32'd8);
        check("ped_walk_main", 32'(main_lights), 32'b100);
        step(32);
        check("ped_arb_state", 32'(state), 32'd6);
        check("ped_arb_walk", 32'(walk), 32'd0);
        step(4);
        check("ped_mg_state", 32'(state), 32'd0);

        // Press during walk with car waiting: side green, then walk again
        ped_btn = 1'b1;
        step(1);
        ped_btn = 1'b0;
        step(39);
        check("pw_my_state", 32'(state), 32'd1);
        step(16);
        check("pw_walk1_state", 32'(state), 32'd3);
        car_side = 1'b1;
        ped_btn  = 1'b1;
        step(1);
        ped_btn = 1'b0;
        step(30);
        check("pw_walk_end_state", 32'(state), 32'd3);
        step(1);
        check("pw_sg_state", 32'(state), 32'd4);
        check("pw_sg_pend", 32'(dut.ped_pending_q), 32'd1);
        step(56);
        check("pw_mg_state", 32'(state), 32'd0);
        step(39);
        check("pw_mg_last_state", 32'(state), 32'd0);
        step(1);
        check("pw_my_state2", 32'(state), 32'd1);
        step(16);
        check("pw_walk2_state", 32'(state), 32'd3);
        car_side = 1'b0;
        step(32);
        check("pw_arb_state", 32'(state), 32'd6);
        step(4);
        check("pw_mg2_state", 32'(state), 32'd0);

        // Reset pulse in the middle of side green
        car_side = 1'b1;
        step(40);
        step(16);
        check("mr_sg_state", 32'(state), 32'd4);
        car_side = 1'b0;
        step(10);
        reset_n = 1'b0;
        step(1);
        check("mr_state", 32'(state), 32'd6);
        check("mr_main", 32'(main_lights), 32'b100);
        check("mr_side", 32'(side_lights), 32'b100);
        check("mr_sec", 32'(sec_remaining), 32'd1);
        check("mr_pend", 32'(dut.ped_pending_q), 32'd0);
        reset_n = 1'b1;
        step(3);
        check("mr_c3_state", 32'(state), 32'd6);
        step(1);
        check("mr_c4_state", 32'(state), 32'd0);

        // Illegal encoding recovers to ALL_RED_B
        step(5);
        force dut.state_q = 3'd7;
        #1;
        check("ill_forced", 32'(state), 32'd7);
        release dut.state_q;
        step(1);
        check("ill_rec_state", 32'(state), 32'd6);
        check("ill_rec_sec", 32'(sec_remaining), 32'd1);
        check("ill_rec_main", 32'(main_lights), 32'b100);
        step(4);
        check("ill_mg_state", 32'(state), 32'd0);
        check("ill_mg_sec", 32'(sec_remaining), 32'd30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
